// File: rtl/pi1_timer.sv
// rtl/pi1_timer.sv - prescaled 32-bit timer with compare match and interrupt request for the pi1r bus
module pi1_timer #(
  parameter int ARCHBITSZ = 32,
  parameter int PRESCALE  = 100,
  parameter int MAPSZ     = 'h1000 / (ARCHBITSZ / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ARCHBITSZ-3:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ARCHBITSZ-3:0]   pi1_mapsz_o,
  output logic                   intrqst_o,
  input  logic                   intrdy_i
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [ARCHBITSZ-1:0] cnt, cmp;
  logic [2:0]           ctrl;
  logic                 pend, ack;
  logic [PW-1:0]        presc;

  logic                 wr_en, rd_en;
  logic                 wr_cnt, wr_cmp, wr_ctrl, wr_stat;
  logic                 w1c, presc_wrap, tick, match;
  logic [2:0]           ctrl_next;
  logic [ARCHBITSZ-1:0] rdata;
  logic                 unused_addr;

  function automatic logic [ARCHBITSZ-1:0] merge_bytes(
    input logic [ARCHBITSZ-1:0]   old_val,
    input logic [ARCHBITSZ-1:0]   new_val,
    input logic [ARCHBITSZ/8-1:0] sel
  );
    logic [ARCHBITSZ-1:0] r;
    r = old_val;
    for (int i = 0; i < ARCHBITSZ / 8; i++) begin
      if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = (ARCHBITSZ-2)'(MAPSZ);
  assign unused_addr = ^pi1_addr_i[ARCHBITSZ-3:2];

  always_comb begin
    wr_en     = pi1_op_i[0];
    rd_en     = pi1_op_i[1];
    wr_cnt    = wr_en && (pi1_addr_i[1:0] == 2'd0);
    wr_cmp    = wr_en && (pi1_addr_i[1:0] == 2'd1);
    wr_ctrl   = wr_en && (pi1_addr_i[1:0] == 2'd2);
    wr_stat   = wr_en && (pi1_addr_i[1:0] == 2'd3);
    w1c       = wr_stat && pi1_sel_i[0] && pi1_data_i[0];
    ctrl_next = (wr_ctrl && pi1_sel_i[0]) ? pi1_data_i[2:0] : ctrl;
    // A tick is lost if EN is being cleared this cycle or software is overwriting CNT.
    presc_wrap = ctrl[0] && (presc == PRESC_LAST);
    tick       = presc_wrap && ctrl_next[0] && !wr_cnt;
    match      = tick && (cnt == cmp);
    case (pi1_addr_i[1:0])
      2'd0:    rdata = cnt;
      2'd1:    rdata = cmp;
      2'd2:    rdata = {{(ARCHBITSZ-3){1'b0}}, ctrl};
      default: rdata = {{(ARCHBITSZ-1){1'b0}}, pend};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      cmp        <= '1;
      ctrl       <= '0;
      pend       <= 1'b0;
      ack        <= 1'b0;
      presc      <= '0;
      pi1_data_o <= '0;
      intrqst_o  <= 1'b0;
    end else begin
      if (rd_en) pi1_data_o <= rdata;
      if (wr_cmp) cmp <= merge_bytes(cmp, pi1_data_i, pi1_sel_i);
      ctrl  <= ctrl_next;
      presc <= (ctrl[0] && !presc_wrap) ? presc + 1'b1 : '0;

      if (wr_cnt)
        cnt <= merge_bytes(cnt, pi1_data_i, pi1_sel_i);
      else if (tick)
        cnt <= (match && ctrl[1]) ? '0 : cnt + 1'b1;

      if (match)    pend <= 1'b1;
      else if (w1c) pend <= 1'b0;

      if (w1c && !match)             ack <= 1'b0;
      else if (intrqst_o && intrdy_i) ack <= 1'b1;

      // The handshake term keeps an accepted request from lingering a second cycle.
      intrqst_o <= pend && ctrl[2] && !ack && !(intrqst_o && intrdy_i);
    end
  end

endmodule

// File: doc/pi1_timer.md
Name: pi1_timer

Overview:
- Memory-mapped programmable timer and interrupt source on the pi1r interconnect, in a slave slot like uart/dma.
- Its interrupt request feeds one intctrl source input (intrqst/intrdy pair); it is an upstream producer for intctrl.
- Provides a prescaled 32-bit up-counter, a compare register, and one-shot or periodic interrupt generation for the OS tick.

Parameters:
- ARCHBITSZ, 32, data width; only 32 is supported.
- PRESCALE, 100, clk_i cycles per counter tick; must be >= 1.
- MAPSZ, 'h1000/(ARCHBITSZ/8), mapped size in words, driven on pi1_mapsz_o.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous active-high reset.
- pi1_op_i  in  2  0 = NOOP, 1 = WR, 2 = RD, 3 = RDWR (swap).
- pi1_addr_i  in  ARCHBITSZ-2  word address; only bits [1:0] are decoded.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables for writes.
- pi1_rdy_o  out  1  slave ready.
- pi1_mapsz_o  out  ARCHBITSZ-2  constant MAPSZ.
- intrqst_o  out  1  interrupt request to intctrl.
- intrdy_i  in  1  intctrl ready/accept.

Behaviour:
- Register map (word offset):
  - 0 CNT: counter.
  - 1 CMP: compare value.
  - 2 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
  - 3 STAT: bit0 PEND, write-1-to-clear; other bits read 0.
- Reset values: CNT=0, CMP=0xFFFFFFFF, CTRL=0, PEND=0, prescaler=0, ACK=0, pi1_data_o=0, intrqst_o=0. pi1_rdy_o is constant 1.
- Bus access:
  - An op is accepted in any cycle with pi1_op_i != 0.
  - Read data is registered and valid on pi1_data_o the cycle after acceptance. It holds until the next accepted read.
  - WR updates the selected bytes at the clock edge of acceptance.
  - RDWR returns the pre-write value and applies the write in the same edge.
  - sel_i=0 writes nothing.
- Prescaler:
  - 0..PRESCALE-1 counter, running only when EN=1.
  - A tick occurs on the cycle the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - EN=0 clears the prescaler.
  - PRESCALE=1 gives a tick every cycle.
- On tick:
  - If CNT==CMP: PEND<=1. Then CNT<=0 if PERIODIC, else CNT<=CNT+1.
  - Otherwise CNT<=CNT+1, wrapping 0xFFFFFFFF to 0 with no flag.
- Simultaneous events:
  - A CNT bus write in the same cycle as a tick wins; the tick is discarded. The prescaler still resets.
  - A CMP write takes effect for the next tick.
  - A PEND set (match) in the same cycle as a W1C clear: set wins.
  - A CTRL write with EN 1->0 in a tick cycle suppresses that tick.
- Interrupt handshake:
  - intrqst_o = PEND & IE & !ACK, registered, so it rises 1 cycle after its condition holds.
  - Acceptance: the cycle where intrqst_o && intrdy_i. ACK<=1 at that edge, and intrqst_o drops the next cycle.
  - ACK clears when PEND is cleared. A new match while ACK=1 and PEND=1 does not re-request.
  - IE 1->0 while intrqst_o=1 and not yet accepted drops intrqst_o next cycle; PEND is retained.
- Reset mid-operation:
  - rst_i overrides all bus writes and ticks in that cycle.
  - An outstanding request is withdrawn: intrqst_o=0 the next cycle.
- Unmapped offsets do not exist: only bits [1:0] are decoded, so every address aliases into the 4 registers.

Test Plan:
- Reset, then RD offsets 0..3 -> data 0x0, 0xFFFFFFFF, 0x0, 0x0, each on the cycle after the op; intrqst_o=0.
- PRESCALE=4; WR CMP=3; WR CTRL=0b111.
  - Required: PEND=1 at 16 clocks after CTRL write (match on 4th tick).
  - Required: CNT back to 0 at the same edge.
  - Required: intrqst_o rises 1 cycle later.
  - Required: holding intrdy_i=1 drops intrqst_o after 1 cycle.
  - Required: W1C STAT=1 re-arms; next request 16 clocks later.
- One-shot: CTRL=0b101, CMP=2.
  - Required: PEND set when CNT==2; CNT continues 3, 4, ...
  - Required: WR CNT=0xFFFFFFFF, then the next tick reads 0 with no PEND.
- Collisions:
  - WR CNT=0x10 in a tick cycle -> CNT reads 0x10, not 0x11.
  - Match and STAT W1C in the same cycle -> PEND stays 1.
- RDWR to CMP with data 0x55, sel=0b0001, old CMP 0xFFFFFFFF -> returns 0xFFFFFFFF; CMP becomes 0xFFFFFF55.
- Assert rst_i while intrqst_o=1 and intrdy_i=0 -> intrqst_o=0, CTRL=0, CNT=0 next cycle; no request after reset deasserts.
